// File: rtl/sram_arbiter_ctrl.sv
// Two-master arbiter and access sequencer for a 32-bit external async SRAM
// built from two 16-bit chips (chip 0 = data[15:0], chip 1 = data[31:16]).
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   mN_req/we/addr/be/wdata           master N request (held until ack)
//   mN_rdata/ack                      master N read data, one-cycle ack pulse
//   ram_addr, ram_data_read/write     SRAM address and split data bus
//   ram_data_is_output                1 = controller drives the data bus
//   ram_ce_n/lb_n/ub_n/we_n/oe_n      per-chip active-low strobes
// Every output is a flop; the strobes are computed from the next state so
// they line up with the state the FSM is entering.
module sram_arbiter_ctrl #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [17:0] m0_addr,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [17:0] m1_addr,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [17:0] ram_addr,
  input  logic [31:0] ram_data_read,
  output logic [31:0] ram_data_write,
  output logic        ram_data_is_output,
  output logic [1:0]  ram_ce_n,
  output logic [1:0]  ram_lb_n,
  output logic [1:0]  ram_ub_n,
  output logic [1:0]  ram_we_n,
  output logic [1:0]  ram_oe_n
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [17:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              is_out_q, is_out_d;
  logic [1:0]        ce_n_q, ce_n_d, lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic [1:0]        we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic [1:0]        lane_n;
  logic [31:0]       rd_mask;

  // State, latched request and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      is_out_q   <= 1'b0;
      ce_n_q     <= 2'b11;
      lb_n_q     <= 2'b11;
      ub_n_q     <= 2'b11;
      we_n_q     <= 2'b11;
      oe_n_q     <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      is_out_q   <= is_out_d;
      ce_n_q     <= ce_n_d;
      lb_n_q     <= lb_n_d;
      ub_n_q     <= ub_n_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
    end
  end

  // Byte enables of unselected lanes zero the captured read data
  assign rd_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  // Next state, arbitration, capture and next-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    is_out_d   = 1'b0;
    ce_n_d     = 2'b11;
    lb_n_d     = 2'b11;
    ub_n_d     = 2'b11;
    we_n_d     = 2'b11;
    oe_n_d     = 2'b11;
    lane_n     = 2'b11;

    unique case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          // Round-robin pointer only moves when both masters contend
          if (m0_req && m1_req) begin
            gnt_d  = ~last_q;
            last_d = ~last_q;
          end else begin
            gnt_d = m1_req;
          end
          we_d    = gnt_d ? m1_we    : m0_we;
          addr_d  = gnt_d ? m1_addr  : m0_addr;
          be_d    = gnt_d ? m1_be    : m0_be;
          wdata_d = gnt_d ? m1_wdata : m0_wdata;
          cnt_d   = '0;
          state_d = we_d ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == RD_LAST) begin
          if (gnt_q) m1_rdata_d = ram_data_read & rd_mask;
          else       m0_rdata_d = ram_data_read & rd_mask;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
        else                  cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // A chip is selected only if one of its two byte lanes is enabled
    lane_n = ~{|be_d[3:2], |be_d[1:0]};

    unique case (state_d)
      S_RD: begin
        ce_n_d = lane_n;
        lb_n_d = ~{be_d[2], be_d[0]};
        ub_n_d = ~{be_d[3], be_d[1]};
        oe_n_d = lane_n;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_n_d   = lane_n;
        lb_n_d   = ~{be_d[2], be_d[0]};
        ub_n_d   = ~{be_d[3], be_d[1]};
        is_out_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_n_d   = lane_n;
        lb_n_d   = ~{be_d[2], be_d[0]};
        ub_n_d   = ~{be_d[3], be_d[1]};
        we_n_d   = lane_n;
        is_out_d = 1'b1;
      end
      S_DONE: begin
        m0_ack_d = ~gnt_d;
        m1_ack_d = gnt_d;
      end
      default: ;
    endcase
  end

  assign m0_rdata           = m0_rdata_q;
  assign m1_rdata           = m1_rdata_q;
  assign m0_ack             = m0_ack_q;
  assign m1_ack             = m1_ack_q;
  assign ram_addr           = addr_q;
  assign ram_data_write     = wdata_q;
  assign ram_data_is_output = is_out_q;
  assign ram_ce_n           = ce_n_q;
  assign ram_lb_n           = lb_n_q;
  assign ram_ub_n           = ub_n_q;
  assign ram_we_n           = we_n_q;
  assign ram_oe_n           = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl with a behavioural two-chip SRAM,
// a reference memory and a scoreboard of expected completions.
module tb_sram_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [17:0] m0_addr, m1_addr;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic [17:0] ram_addr;
  logic [31:0] ram_data_read, ram_data_write;
  logic        ram_data_is_output;
  logic [1:0]  ram_ce_n, ram_lb_n, ram_ub_n, ram_we_n, ram_oe_n;

  sram_arbiter_ctrl #(.RD_CYCLES(2), .WR_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_addr(ram_addr), .ram_data_read(ram_data_read),
    .ram_data_write(ram_data_write), .ram_data_is_output(ram_data_is_output),
    .ram_ce_n(ram_ce_n), .ram_lb_n(ram_lb_n), .ram_ub_n(ram_ub_n),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int contention = 0;

  typedef struct {
    bit          m;
    logic [31:0] rd;
  } sb_t;
  sb_t sb[$];

  logic [31:0] sram_mem [logic [17:0]];
  logic [31:0] ref_mem  [logic [17:0]];

  // Per-cycle pin history of the most recent transaction (index = cycle)
  logic [1:0] ce_h [0:31];
  logic [1:0] we_h [0:31];
  logic [1:0] oe_h [0:31];
  logic       out_h[0:31];

  function automatic logic [31:0] sram_word(input logic [17:0] a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [17:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // SRAM read side: undriven chip halves float to a recognisable pattern
  always_comb begin
    logic [31:0] w;
    w = sram_word(ram_addr);
    ram_data_read[15:0]  = ram_oe_n[0] ? 16'hA5A5 : w[15:0];
    ram_data_read[31:16] = ram_oe_n[1] ? 16'hA5A5 : w[31:16];
  end

  // SRAM write side and bus-contention monitor
  always @(posedge clk) begin
    logic [31:0] w;
    if (ram_data_is_output && ram_oe_n != 2'b11) contention++;
    w = sram_word(ram_addr);
    for (int c = 0; c < 2; c++) begin
      if (!ram_ce_n[c] && !ram_we_n[c] && ram_data_is_output) begin
        if (!ram_lb_n[c]) w[16*c +: 8]     = ram_data_write[16*c +: 8];
        if (!ram_ub_n[c]) w[16*c + 8 +: 8] = ram_data_write[16*c + 8 +: 8];
      end
    end
    sram_mem[ram_addr] = w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input logic req, input logic we, input logic [17:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_be = be; m1_wdata = wd;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_be = be; m0_wdata = wd;
    end
  endtask

  // One transaction from IDLE; returns the ack cycle (0 on timeout)
  task automatic txn(input bit m, input logic we, input logic [17:0] a,
                     input logic [3:0] be, input logic [31:0] wd, output int lat);
    sb_t e;
    logic [31:0] got;
    lat = 0;
    drive(m, 1'b1, we, a, be, wd);
    if (we) ref_mem[a] = (ref_word(a) & ~be_mask(be)) | (wd & be_mask(be));
    sb.push_back('{m: m, rd: ref_word(a) & be_mask(be)});
    for (int c = 1; c < 32; c++) begin
      tick();
      ce_h[c] = ram_ce_n; we_h[c] = ram_we_n; oe_h[c] = ram_oe_n;
      out_h[c] = ram_data_is_output;
      if ((m ? m0_ack : m1_ack) == 1'b1) chk("other_ack", 1, 0);
      if ((m ? m1_ack : m0_ack) == 1'b1) begin
        lat = c;
        e = sb.pop_front();
        got = m ? m1_rdata : m0_rdata;
        if (!we) chk($sformatf("rdata_%0h", a), got, e.rd);
        chk("done_is_output", 32'(ram_data_is_output), 0);
        break;
      end
    end
    if (lat == 0) begin
      chk("ack_timeout", 1, 0);
      void'(sb.pop_front());
    end
    drive(m, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);
    tick();
  endtask

  initial begin
    int lat;
    int cnt0, cnt1, cyc;
    sb_t e;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);

    // Reset values
    repeat (3) tick();
    chk("rst_ce_n", 32'(ram_ce_n), 32'h3);
    chk("rst_we_oe_lb_ub", 32'({ram_we_n, ram_oe_n, ram_lb_n, ram_ub_n}), 32'hFF);
    chk("rst_is_output", 32'(ram_data_is_output), 0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_addr_wdata", 32'(ram_addr) | ram_data_write, 0);
    reset_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ram_ce_n != 2'b11 || ram_data_is_output || m0_ack || m1_ack) lat++;
    end
    chk("idle_quiet", lat, 0);

    // m0 full write
    txn(1'b0, 1'b1, 18'h00010, 4'b1111, 32'hDEADBEEF, lat);
    chk("wr_latency", lat, 5);
    chk("wr_ce_c1", 32'(ce_h[1]), 32'h0);
    chk("wr_we_c1", 32'(we_h[1]), 32'h3);
    chk("wr_we_c2c3", 32'({we_h[2], we_h[3]}), 32'h0);
    chk("wr_we_c4", 32'(we_h[4]), 32'h3);
    chk("wr_out_c1_4", 32'({out_h[1], out_h[2], out_h[3], out_h[4]}), 32'hF);
    chk("wr_oe_c1_4", 32'({oe_h[1], oe_h[2], oe_h[3], oe_h[4]}), 32'hFF);
    chk("sram_word_10", sram_word(18'h00010), 32'hDEADBEEF);

    // m0 read-back
    txn(1'b0, 1'b0, 18'h00010, 4'b1111, 32'h0, lat);
    chk("rd_latency", lat, 3);
    chk("rd_oe_c1c2", 32'({oe_h[1], oe_h[2]}), 32'h0);
    chk("rd_out_c1c2", 32'({out_h[1], out_h[2]}), 32'h0);

    // Partial write / read on byte 2 only (chip 1 lower byte)
    drive(1'b1, 1'b1, 1'b1, 18'h00020, 4'b0100, 32'h00AB0000);
    tick();
    chk("pw_ce_n", 32'(ram_ce_n), 32'h1);
    chk("pw_lb_n", 32'(ram_lb_n), 32'h1);
    chk("pw_ub_n", 32'(ram_ub_n), 32'h3);
    drive(1'b1, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);
    for (int c = 0; c < 10 && !m1_ack; c++) tick();
    chk("pw_ack", 32'(m1_ack), 1);
    ref_mem[18'h00020] = 32'h00AB0000;
    tick();
    txn(1'b1, 1'b0, 18'h00020, 4'b0100, 32'h0, lat);
    chk("pr_latency", lat, 3);

    // Empty byte enable: same timing, no strobes, zero data
    txn(1'b0, 1'b0, 18'h00010, 4'b0000, 32'h0, lat);
    chk("be0_latency", lat, 3);
    chk("be0_ce", 32'({ce_h[1], ce_h[2], oe_h[1], oe_h[2]}), 32'hFF);

    // Seed data for contention test
    txn(1'b0, 1'b1, 18'h00100, 4'b1111, 32'h11111111, lat);
    txn(1'b1, 1'b1, 18'h00200, 4'b1111, 32'h22222222, lat);

    // Contention from a fresh reset: grants must alternate m0,m1,...
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{m: 1'b0, rd: 32'h11111111});
      sb.push_back('{m: 1'b1, rd: 32'h22222222});
    end
    drive(1'b0, 1'b1, 1'b0, 18'h00100, 4'b1111, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 18'h00200, 4'b1111, 32'h0);
    cnt0 = 0; cnt1 = 0; cyc = 0;
    while ((cnt0 < 3 || cnt1 < 3) && cyc < 200) begin
      tick();
      cyc++;
      if (m0_ack && m1_ack) chk("ack_overlap", 1, 0);
      if ((m0_ack || m1_ack) && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rr_grant", 32'(m1_ack), 32'(e.m));
        chk("rr_rdata", m1_ack ? m1_rdata : m0_rdata, e.rd);
        chk("rr_done_is_output", 32'(ram_data_is_output), 0);
        if (m0_ack) begin cnt0++; if (cnt0 == 3) m0_req = 1'b0; end
        if (m1_ack) begin cnt1++; if (cnt1 == 3) m1_req = 1'b0; end
      end
    end
    chk("rr_complete", 32'(cnt0 + cnt1), 6);
    drive(1'b0, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);
    sb.delete();
    repeat (2) tick();

    // Reset during WR_PULSE
    drive(1'b0, 1'b1, 1'b1, 18'h00300, 4'b1111, 32'hCAFEF00D);
    cyc = 0;
    while (ram_we_n != 2'b00 && cyc < 10) begin tick(); cyc++; end
    chk("mid_reached_pulse", 32'(ram_we_n), 32'h0);
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 18'h0, 4'h0, 32'h0);
    tick();
    chk("mid_we_n", 32'(ram_we_n), 32'h3);
    chk("mid_is_output", 32'(ram_data_is_output), 0);
    chk("mid_ce_n", 32'(ram_ce_n), 32'h3);
    reset_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m0_ack || m1_ack) lat++;
    end
    chk("mid_no_ack", lat, 0);
    chk("bus_contention", contention, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
